// File: rtl/tetris_pkg.sv
// Shared types and default timing constants for the Tetris input path.
// All timings assume the 50 MHz vclk.
`timescale 1ns/1ps
package tetris_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    localparam int DEBOUNCE_10MS = 500000;
    localparam int REPEAT_300MS  = 15000000;
    localparam int REPEAT_100MS  = 5000000;

endpackage

// File: rtl/btn_repeat_debounce_sync2.sv
// Two-flop synchroniser for one asynchronous input.
// Both flops reset to 0.
`timescale 1ns/1ps
module sync2 (
    input  logic vclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_r;
    logic s2_r;

    // metastability filter: d -> s1 -> s2
    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule

// File: rtl/btn_repeat_debounce.sv
// One push-button conditioner: synchroniser, stability-count debounce and
// hold/auto-repeat FSM producing one-cycle move strobes for Game_Logic.
`timescale 1ns/1ps
module btn_repeat_debounce
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY = REPEAT_300MS,
    parameter int REPEAT_RATE  = REPEAT_100MS,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int CNT_W        = 24
) (
    input  logic vclk,
    input  logic rst,
    input  logic button,
    input  logic en,
    output logic level,
    output logic pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEB_TC   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_TC   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(REPEAT_RATE - 1);

    logic             s2_s;
    logic             level_r;
    logic             level_nxt_s;
    logic [CNT_W-1:0] dcnt_r;
    logic [CNT_W-1:0] dcnt_nxt_s;
    logic             rise_s;
    btn_state_e       state_r;
    logic [CNT_W-1:0] rcnt_r;
    logic             pulse_r;
    logic             held_r;

    sync2 u_sync (
        .vclk (vclk),
        .rst  (rst),
        .d    (button),
        .q    (s2_s)
    );

    // next debounced level: flips only after DEBOUNCE_CYC consecutive disagreeing samples
    always_comb begin
        level_nxt_s = level_r;
        dcnt_nxt_s  = dcnt_r;
        if (s2_s == level_r) begin
            dcnt_nxt_s = CNT_ZERO;
        end else if (dcnt_r == DEB_TC) begin
            level_nxt_s = s2_s;
            dcnt_nxt_s  = CNT_ZERO;
        end else begin
            dcnt_nxt_s = dcnt_r + CNT_ONE;
        end
    end

    // debounce state registers
    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            level_r <= 1'b0;
            dcnt_r  <= CNT_ZERO;
        end else begin
            level_r <= level_nxt_s;
            dcnt_r  <= dcnt_nxt_s;
        end
    end

    // FSM reacts to the level being committed on this edge, so press and release
    // act on the same edge the debounced level changes
    assign rise_s = level_nxt_s & ~level_r;

    // hold/auto-repeat FSM with registered pulse and held
    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            rcnt_r  <= CNT_ZERO;
            pulse_r <= 1'b0;
            held_r  <= 1'b0;
        end else begin
            pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    rcnt_r <= CNT_ZERO;
                    if (rise_s) begin
                        pulse_r <= en;
                        state_r <= HOLD;
                        held_r  <= 1'b1;
                    end else begin
                        held_r  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!level_nxt_s) begin
                        state_r <= IDLE;
                        rcnt_r  <= CNT_ZERO;
                        held_r  <= 1'b0;
                    end else if (REPEAT_EN && (rcnt_r == DLY_TC)) begin
                        pulse_r <= en;
                        rcnt_r  <= CNT_ZERO;
                        state_r <= REPEAT;
                        held_r  <= 1'b1;
                    end else if (rcnt_r != DLY_TC) begin
                        rcnt_r  <= rcnt_r + CNT_ONE;
                        held_r  <= 1'b1;
                    end else begin
                        // repeat disabled: park at terminal count instead of wrapping
                        rcnt_r  <= rcnt_r;
                        held_r  <= 1'b1;
                    end
                end
                REPEAT: begin
                    if (!level_nxt_s) begin
                        state_r <= IDLE;
                        rcnt_r  <= CNT_ZERO;
                        held_r  <= 1'b0;
                    end else if (rcnt_r == RATE_TC) begin
                        pulse_r <= en;
                        rcnt_r  <= CNT_ZERO;
                        held_r  <= 1'b1;
                    end else begin
                        rcnt_r  <= rcnt_r + CNT_ONE;
                        held_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rcnt_r  <= CNT_ZERO;
                    held_r  <= 1'b0;
                end
            endcase
        end
    end

    assign level = level_r;
    assign pulse = pulse_r;
    assign held  = held_r;

endmodule

// File: tb/tb_btn_repeat_debounce.sv
// Self-checking bench: two instances (auto-repeat on/off) against a timing model
// built from stability windows and time-since-press arithmetic.
`timescale 1ns/1ps
module tb_btn_repeat_debounce;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    logic vclk = 1'b0;
    logic rst;
    logic button;
    logic en;
    logic level0, pulse0, held0;
    logic level1, pulse1, held1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 vclk = ~vclk;

    btn_repeat_debounce #(.DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                          .REPEAT_EN(1'b1), .CNT_W(24)) u_rep (
        .vclk(vclk), .rst(rst), .button(button), .en(en),
        .level(level0), .pulse(pulse0), .held(held0));

    btn_repeat_debounce #(.DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                          .REPEAT_EN(1'b0), .CNT_W(24)) u_norep (
        .vclk(vclk), .rst(rst), .button(button), .en(en),
        .level(level1), .pulse(pulse1), .held(held1));

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic m_s1, m_s2, m_level;
    logic m_hist [DEB];
    bit   m_act  [2];
    int   m_t    [2];
    logic m_pulse[2];

    task automatic m_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
        for (int i = 0; i < DEB; i++) m_hist[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0; m_t[k] = 0; m_pulse[k] = 1'b0;
        end
    endtask

    task automatic m_step();
        logic old_lvl;
        logic new_lvl;
        bit   all_diff;
        for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = m_s2;
        all_diff = 1'b1;
        for (int i = 0; i < DEB; i++) if (m_hist[i] == m_level) all_diff = 1'b0;
        old_lvl = m_level;
        new_lvl = all_diff ? ~old_lvl : old_lvl;
        m_s2 = m_s1;
        m_s1 = button;
        for (int k = 0; k < 2; k++) begin
            if (m_act[k]) begin
                if (!new_lvl) begin
                    m_act[k] = 1'b0;
                    m_pulse[k] = 1'b0;
                end else begin
                    m_t[k]++;
                    m_pulse[k] = en && (k == 0) && (m_t[k] >= RD) && (((m_t[k] - RD) % RR) == 0);
                end
            end else if (!old_lvl && new_lvl) begin
                m_act[k] = 1'b1;
                m_t[k] = 0;
                m_pulse[k] = en;
            end else begin
                m_pulse[k] = 1'b0;
            end
        end
        m_level = new_lvl;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge vclk or negedge rst);
            if (!rst) m_reset();
            else m_step();
        end
    end

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge vclk);
            check("cmp_level_rep",   level0, m_level);
            check("cmp_pulse_rep",   pulse0, m_pulse[0]);
            check("cmp_held_rep",    held0,  logic'(m_act[0]));
            check("cmp_level_norep", level1, m_level);
            check("cmp_pulse_norep", pulse1, m_pulse[1]);
            check("cmp_held_norep",  held1,  logic'(m_act[1]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge vclk);
        #1;
    endtask

    task automatic run_count(input int n, inout int c0, inout int c1);
        for (int i = 0; i < n; i++) begin
            step(1);
            if (pulse0 === 1'b1) c0++;
            if (pulse1 === 1'b1) c1++;
        end
    endtask

    int c0, c1;

    initial begin
        rst = 1'b0; button = 1'b0; en = 1'b1;
        step(3);
        check("reset_level", level0, 1'b0);
        check("reset_pulse", pulse0, 1'b0);
        check("reset_held",  held0,  1'b0);
        rst = 1'b1;
        step(3);

        // clean press, then hold 40 cycles total
        button = 1'b1;
        step(5);
        check("t1_level_e5", level0, 1'b0);
        check("t1_pulse_e5", pulse0, 1'b0);
        step(1);
        check("t1_level_e6", level0, 1'b1);
        check("t1_pulse_e6", pulse0, 1'b1);
        check("t1_held_e6",  held0,  1'b1);
        check("t1_pulse1_e6", pulse1, 1'b1);
        step(1);
        check("t1_pulse_e7", pulse0, 1'b0);
        c0 = 0; c1 = 0;
        run_count(33, c0, c1);
        check("t3_repeats_e8_40", logic'(c0 == 9), 1'b1);
        button = 1'b0;
        run_count(4, c0, c1);
        check("t3_level_e44", level0, 1'b1);
        step(1);
        check("t3_level_e45", level0, 1'b1);
        step(1);
        check("t3_level_e46", level0, 1'b0);
        check("t3_pulse_e46", pulse0, 1'b0);
        check("t3_held_e46",  held0,  1'b0);
        c0 = c0 + 0;
        run_count(10, c0, c1);
        check("t3_total_repeats", logic'(c0 == 10), 1'b1);
        check("t3_norep_pulses",  logic'(c1 == 0), 1'b1);

        // bounce for 20 cycles, then stable high
        c0 = 0; c1 = 0;
        for (int i = 0; i < 20; i++) begin
            button = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            run_count(1, c0, c1);
        end
        check("t2_level_bounce", level0, 1'b0);
        button = 1'b1;
        run_count(5, c0, c1);
        check("t2_level_e5", level0, 1'b0);
        run_count(1, c0, c1);
        check("t2_level_e6", level0, 1'b1);
        check("t2_pulse_e6", pulse0, 1'b1);
        run_count(3, c0, c1);
        button = 1'b0;
        run_count(12, c0, c1);
        check("t2_one_pulse_rep",   logic'(c0 == 1), 1'b1);
        check("t2_one_pulse_norep", logic'(c1 == 1), 1'b1);

        // release colliding with repeat terminal count
        button = 1'b1;
        step(16);
        button = 1'b0;
        step(3);
        check("t4_pulse_e19", pulse0, 1'b1);
        step(3);
        check("t4_pulse_e22", pulse0, 1'b0);
        check("t4_held_e22",  held0,  1'b0);
        check("t4_level_e22", level0, 1'b0);
        step(10);

        // REPEAT_EN=0 held 100 cycles
        c0 = 0; c1 = 0;
        button = 1'b1;
        run_count(100, c0, c1);
        check("t4_norep_held", held1, 1'b1);
        button = 1'b0;
        run_count(10, c0, c1);
        check("t4_norep_single", logic'(c1 == 1), 1'b1);

        // en low through the hold, raised mid-hold
        en = 1'b0;
        c0 = 0; c1 = 0;
        button = 1'b1;
        run_count(17, c0, c1);
        check("t5_no_pulse", logic'(c0 == 0 && c1 == 0), 1'b1);
        check("t5_held",  held0,  1'b1);
        check("t5_level", level0, 1'b1);
        en = 1'b1;
        step(1);
        check("t5_pulse_e18", pulse0, 1'b0);
        step(1);
        check("t5_pulse_e19", pulse0, 1'b1);
        button = 1'b0;
        step(12);

        // async reset mid-REPEAT with the button held
        button = 1'b1;
        step(20);
        check("t6_held_before", held0, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_level", level0, 1'b0);
        check("t6_rst_pulse", pulse0, 1'b0);
        check("t6_rst_held",  held0,  1'b0);
        step(2);
        rst = 1'b1;
        step(5);
        check("t6_level_e5", level0, 1'b0);
        step(1);
        check("t6_pulse_e6", pulse0, 1'b1);
        check("t6_level_e6", level0, 1'b1);
        check("t6_pulse1_e6", pulse1, 1'b1);
        button = 1'b0;
        step(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before t=%0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
